// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Sends a start bit, 7 data bits
//               (LSB first), a parity bit and 1 or 2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] p_din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int             c_CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [2:0]     c_LAST_DATA = 3'd7;
    localparam logic [2:0]     c_LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_n;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_n;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_n;
    logic             w_bit_end;
    logic             w_tx_n;
    logic             w_busy_n;
    logic             w_done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shreg <= w_shreg_n;
            tx      <= w_tx_n;
            tx_busy <= w_busy_n;
            tx_done <= w_done_n;
        end
    end

    assign w_bit_end = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shreg_n = r_shreg;

        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                w_idx_n = '0;
                if (tx_start) begin
                    w_shreg_n = p_din;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_state_n = S_DATA;
                end else begin
                    w_cnt_n = r_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    if (r_idx == c_LAST_DATA) begin
                        w_idx_n   = '0;
                        w_state_n = S_STOP;
                    end else begin
                        w_idx_n   = r_idx + 3'd1;
                        w_shreg_n = {1'b0, r_shreg[7:1]};
                    end
                end else begin
                    w_cnt_n = r_cnt + c_CNT_ONE;
                end
            end
            S_STOP: begin
                // r_idx is reused to count stop bits
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    if (r_idx == c_LAST_STOP) begin
                        w_idx_n   = '0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they are registered and glitch-free
    always_comb begin
        w_tx_n   = 1'b1;
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (r_state == S_STOP) && (w_state_n == S_IDLE);
        case (w_state_n)
            S_START: w_tx_n = 1'b0;
            S_DATA:  w_tx_n = w_shreg_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int c_N = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [c_N-1:0]   start;
    logic [7:0]       din [c_N];
    logic [c_N-1:0]   tx_o;
    logic [c_N-1:0]   busy_o;
    logic [c_N-1:0]   done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_start(start[0]), .p_din(din[0]),
        .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_start(start[1]), .p_din(din[1]),
        .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .tx_start(start[2]), .p_din(din[2]),
        .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));

    function automatic int cpb_of(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    function automatic int ns_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Line bit at frame position pos: start, data[0..6], parity, stop bits
    function automatic logic exp_bit(input logic [7:0] data, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return data[pos-1];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input int k, input logic [7:0] data, input bit hold);
        start[k] = 1'b1;
        din[k]   = data;
        @(negedge clk);
        if (!hold) start[k] = 1'b0;
        din[k] = 8'($urandom);
    endtask

    // Checks every cycle of a frame, then the done cycle; returns at the done negedge
    task automatic check_frame(input int k, input logic [7:0] data, input bit noise);
        int len;
        len = (9 + ns_of(k)) * cpb_of(k);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("tx[%0d] d=%h cyc=%0d", k, data, i), tx_o[k], exp_bit(data, i / cpb_of(k)));
            chk($sformatf("busy[%0d] d=%h cyc=%0d", k, data, i), busy_o[k], 1'b1);
            chk($sformatf("done[%0d] d=%h cyc=%0d", k, data, i), done_o[k], 1'b0);
            if (noise) start[k] = 1'($urandom_range(0, 1));
            din[k] = 8'($urandom);
            @(negedge clk);
        end
        if (noise) start[k] = 1'b0;
        chk($sformatf("done_pulse[%0d] d=%h", k, data), done_o[k], 1'b1);
        chk($sformatf("done_busy[%0d] d=%h", k, data), busy_o[k], 1'b0);
        chk($sformatf("done_tx[%0d] d=%h", k, data), tx_o[k], 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        int         k;
        start = '0;
        for (int i = 0; i < c_N; i++) din[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < c_N; i++) begin
            chk($sformatf("rst_tx[%0d]", i), tx_o[i], 1'b1);
            chk($sformatf("rst_busy[%0d]", i), busy_o[i], 1'b0);
            chk($sformatf("rst_done[%0d]", i), done_o[i], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Reset asserted during data bit 3
        send(0, 8'h55, 1'b0);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("pre_rst_tx cyc=%0d", i), tx_o[0], exp_bit(8'h55, i / 4));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx", tx_o[0], 1'b1);
        chk("midrst_busy", busy_o[0], 1'b0);
        chk("midrst_done", done_o[0], 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done cyc=%0d", i), done_o[0], 1'b0);
            chk($sformatf("post_rst_busy cyc=%0d", i), busy_o[0], 1'b0);
        end
        send(0, 8'h55, 1'b0);
        check_frame(0, 8'h55, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done_o[0], 1'b0);

        // Even parity frame, one stop bit
        send(0, 8'h55, 1'b0);
        check_frame(0, 8'h55, 1'b0);
        @(negedge clk);

        // Odd parity frame, two stop bits
        send(1, 8'hD5, 1'b0);
        check_frame(1, 8'hD5, 1'b0);
        @(negedge clk);
        chk("stop2_idle_done", done_o[1], 1'b0);

        // tx_start/p_din noise while busy must not disturb the frame
        send(0, 8'h00, 1'b0);
        check_frame(0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_requeue_busy cyc=%0d", i), busy_o[0], 1'b0);
            chk($sformatf("no_requeue_done cyc=%0d", i), done_o[0], 1'b0);
            chk($sformatf("no_requeue_tx cyc=%0d", i), tx_o[0], 1'b1);
        end

        // Back-to-back with tx_start held high
        send(0, 8'h01, 1'b1);
        check_frame(0, 8'h01, 1'b0);
        din[0] = 8'h80;
        @(negedge clk);
        start[0] = 1'b0;
        din[0]   = 8'($urandom);
        check_frame(0, 8'h80, 1'b0);
        @(negedge clk);

        // Minimum divider
        send(2, 8'hA3, 1'b0);
        check_frame(2, 8'hA3, 1'b0);
        @(negedge clk);

        // Random payloads across all configurations
        for (int r = 0; r < 9; r++) begin
            k = r % c_N;
            d = 8'($urandom);
            send(k, d, 1'b0);
            check_frame(k, d, r[0]);
            @(negedge clk);
            chk($sformatf("rand_idle_done[%0d]", k), done_o[k], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit serializer for the UART TX path. It sits directly downstream of the parity generator and consumes the 8-bit {parity, data[6:0]} word. It emits an asynchronous serial frame: one start bit, 7 data bits LSB first, the parity bit, then stop bit(s). A parameterized baud counter sets the bit timing, and a start/busy/done handshake connects it to the TX controller.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥2; counter width = clog2(CLKS_PER_BIT).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
tx_start  input  1  request to send; sampled only in IDLE.
p_din  input  8  frame payload from parity generator; [6:0] data, [7] parity bit.
tx  output  1  serial line; idles high.
tx_busy  output  1  high while a frame is in progress (START/DATA/STOP).
tx_done  output  1  one-cycle pulse on frame completion.

Behaviour:
- All outputs registered. Reset values: tx=1, tx_busy=0, tx_done=0. State=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset is synchronous and overrides everything. Reset asserted mid-frame forces the reset values on the next edge. The frame is abandoned and no tx_done is produced.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_start=1 on edge N: latch p_din into the shift register and go to START. tx=0 and tx_busy=1 from cycle N+1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shreg[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit index increments.
  - Order on the line: p_din[0]..p_din[6], then p_din[7] (parity).
  - After bit index 7 completes, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
- tx_done:
  - Asserted for exactly one cycle, in the first IDLE cycle after STOP.
  - tx_busy=0 in that same cycle.
- Frame duration: tx_busy high for exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in START/DATA/STOP and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
  - No drift: every bit is exactly CLKS_PER_BIT cycles.
- tx_start while tx_busy=1 is ignored (no queuing, no effect on the current frame).
- p_din changes after acceptance do not affect the frame in flight.
- tx_start=1 in the tx_done cycle is accepted; the next frame's start bit begins on the following cycle.
- tx_start held high continuously gives back-to-back frames, each separated by the single IDLE/done cycle.
- tx has no glitches: it changes only at bit boundaries.

Test Plan:
1. Reset mid-frame: CLKS_PER_BIT=4; send 8'h55; assert rst for 1 cycle during DATA bit 3 → next cycle tx=1, tx_busy=0. tx_done never pulses for that frame. A new tx_start then produces a clean full frame.
2. Even-parity frame: CLKS_PER_BIT=4, STOP_BITS=1, p_din=8'h55 (data 7'h55, parity 0), tx_start 1 cycle.
   - tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
   - tx_busy high 40 cycles; tx_done pulses on cycle 41 after acceptance.
3. Odd-parity frame, two stop bits: p_din=8'hD5, STOP_BITS=2.
   - Line bits 0,1,0,1,0,1,0,1,1,1,1; tx_busy high 44 cycles.
   - 9th line bit (parity)=1.
4. Busy-ignore and data stability: during a frame of 8'h00, pulse tx_start with p_din=8'hFF at mid-frame → the line still carries all-zero data. Exactly one tx_done; no second frame starts.
5. Back-to-back: tx_start held high, payloads 8'h01 then 8'h80.
   - Exactly one idle-high cycle (the tx_done cycle) between the first frame's stop bit and the second frame's start bit.
   - Both frames are bit-exact.
6. Timing at minimum divider: CLKS_PER_BIT=2, p_din=8'hA3 → every bit is exactly 2 cycles. Frame length is 20 cycles; the line shows 0,1,1,0,0,0,1,0,1,1.
